// File: rtl/sort_8_scheduler.sv
// sort_8_fifo: generic show-ahead FIFO with occupancy count, storage cleared on reset.
// Latency: a write at edge N is visible on pop_dat from the cycle after N.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module sort_8_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// sort_8_scheduler: round-robin issue of A/B vectors to a shared sorter, results returned in issue order with requester id.
// Latency: issue one cycle after acceptance; result visible on m_* one cycle after s_y_valid.
// Backpressure: credit-based; a/b_ready drop when issued-plus-buffered reaches DEPTH, released by m handshakes.
module sort_8_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [8*DATA_WIDTH-1:0]    a_x,
    input  logic [8*LABEL_WIDTH-1:0]   a_x_label,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [8*DATA_WIDTH-1:0]    b_x,
    input  logic [8*LABEL_WIDTH-1:0]   b_x_label,
    output logic                       s_x_valid,
    output logic [8*DATA_WIDTH-1:0]    s_x,
    output logic [8*LABEL_WIDTH-1:0]   s_x_label,
    input  logic                       s_y_valid,
    input  logic [8*DATA_WIDTH-1:0]    s_y,
    input  logic [8*LABEL_WIDTH-1:0]   s_y_label,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [8*DATA_WIDTH-1:0]    m_y,
    output logic [8*LABEL_WIDTH-1:0]   m_y_label,
    output logic                       m_id,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       overflow
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DW8    = 8 * DATA_WIDTH;
    localparam int LW8    = 8 * LABEL_WIDTH;
    localparam int RES_W  = DW8 + LW8 + 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] CREDITS  = (AW+2)'(DEPTH);

    logic [AW:0]      id_count;
    logic [AW:0]      res_count;
    logic [AW+1:0]    used;
    logic             has_credit;
    logic             rr_last_b;
    logic             a_wins;
    logic             b_wins;
    logic             issue;
    logic             issue_id;
    logic             id_head;
    logic             id_empty;
    logic             res_full;
    logic             res_empty;
    logic             sy_take;
    logic             sy_drop;
    logic             m_pop;
    logic [RES_W-1:0] res_push_dat;
    logic [RES_W-1:0] res_head;

    // Credit is implicit: everything issued and not yet delivered occupies one buffer slot
    assign used       = {1'b0, id_count} + {1'b0, res_count};
    assign has_credit = used < CREDITS;

    // rr_last_b=1 means B won last, so A is favoured on a tie
    assign a_wins  = a_valid & (~b_valid | rr_last_b);
    assign b_wins  = b_valid & (~a_valid | ~rr_last_b);
    assign a_ready = ~rst & has_credit & a_wins;
    assign b_ready = ~rst & has_credit & b_wins;

    assign issue    = (a_valid & a_ready) | (b_valid & b_ready);
    assign issue_id = b_valid & b_ready;

    assign id_empty  = (id_count == '0);
    assign res_empty = (res_count == '0);
    assign res_full  = (res_count == FULL_CNT);

    // A return with nothing outstanding or nowhere to land is a sorter protocol error
    assign sy_take = s_y_valid & ~id_empty & ~res_full;
    assign sy_drop = s_y_valid & ~sy_take;

    assign m_valid = ~res_empty;
    assign m_pop   = m_valid & m_ready;

    assign res_push_dat = {s_y, s_y_label, id_head};
    assign {m_y, m_y_label, m_id} = res_head;

    assign inflight = id_count;

    sort_8_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (issue),
        .push_dat (issue_id),
        .pop_vld  (sy_take),
        .pop_dat  (id_head),
        .count    (id_count)
    );

    sort_8_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (sy_take),
        .push_dat (res_push_dat),
        .pop_vld  (m_pop),
        .pop_dat  (res_head),
        .count    (res_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_x_valid <= 1'b0;
            s_x       <= '0;
            s_x_label <= '0;
            rr_last_b <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            s_x_valid <= issue;
            if (issue) begin
                s_x       <= issue_id ? b_x : a_x;
                s_x_label <= issue_id ? b_x_label : a_x_label;
                rr_last_b <= issue_id;
            end
            if (sy_drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sort_8_scheduler.sv
// Directed bench for sort_8_scheduler with a 3-cycle ascending-sort model standing in for the shared sorter.
module tb_sort_8_scheduler;
    logic        clk;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [63:0] a_x, b_x;
    logic [7:0]  a_x_label, b_x_label;
    logic        s_x_valid;
    logic [63:0] s_x;
    logic [7:0]  s_x_label;
    logic        s_y_valid;
    logic [63:0] s_y;
    logic [7:0]  s_y_label;
    logic        m_valid, m_ready, m_id;
    logic [63:0] m_y;
    logic [7:0]  m_y_label;
    logic [2:0]  inflight;
    logic        overflow;

    logic        man_sy;
    logic [63:0] man_y;
    logic [2:0]  pv;
    logic [63:0] pd [3];
    logic [7:0]  pl [3];

    int n_chk = 0;
    int n_err = 0;

    sort_8_scheduler #(.DATA_WIDTH(8), .LABEL_WIDTH(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_x_label(a_x_label),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_x_label(b_x_label),
        .s_x_valid(s_x_valid), .s_x(s_x), .s_x_label(s_x_label),
        .s_y_valid(s_y_valid), .s_y(s_y), .s_y_label(s_y_label),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_y_label(m_y_label), .m_id(m_id),
        .inflight(inflight), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [71:0] sort8(input logic [63:0] x, input logic [7:0] l);
        logic [7:0]  v [8];
        logic        lb [8];
        logic [7:0]  tv;
        logic        tl;
        logic [63:0] ox;
        logic [7:0]  ol;
        for (int i = 0; i < 8; i++) begin
            v[i]  = x[i*8 +: 8];
            lb[i] = l[i];
        end
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    tv = v[j];  v[j]  = v[j+1];  v[j+1]  = tv;
                    tl = lb[j]; lb[j] = lb[j+1]; lb[j+1] = tl;
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            ox[i*8 +: 8] = v[i];
            ol[i]        = lb[i];
        end
        return {ol, ox};
    endfunction

    // Sorter model: captures on the falling edge, result presented three cycles after issue
    always @(negedge clk) begin
        if (rst) begin
            pv <= 3'b000;
        end else begin
            pv <= {pv[1:0], s_x_valid};
            {pl[0], pd[0]} <= sort8(s_x, s_x_label);
            pd[1] <= pd[0]; pl[1] <= pl[0];
            pd[2] <= pd[1]; pl[2] <= pl[1];
        end
    end

    assign s_y_valid = pv[2] | man_sy;
    assign s_y       = man_sy ? man_y : pd[2];
    assign s_y_label = man_sy ? 8'h00 : pl[2];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0; man_sy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    localparam logic [63:0] VEC_A   = 64'h0706050403020100;
    localparam logic [63:0] VEC_B   = 64'h0001020304050607;
    localparam logic [63:0] VEC_C   = 64'h1032547698BADCFE;
    localparam logic [63:0] SORT_AB = 64'h0706050403020100;
    localparam logic [63:0] SORT_C  = 64'hFEDCBA9876543210;

    logic        gq   [$];
    logic        mid  [$];
    logic [7:0]  mlab [$];
    logic [63:0] mdat [$];
    int          n;

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b0; m_ready = 1'b0; man_sy = 1'b0; man_y = '0;
        a_x = VEC_A; a_x_label = 8'hA5; b_x = VEC_B; b_x_label = 8'h01;

        // Reset state
        tick();
        tick();
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_s_x_valid", s_x_valid, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_inflight", inflight, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_s_x", s_x, 64'h0);
        chk("rst_m_y", m_y, 64'h0);
        do_reset();

        // Single A request through the sorter
        a_valid = 1'b1; a_x = VEC_A; a_x_label = 8'hA5;
        #1;
        chk("t1_a_ready", a_ready, 1'b1);
        chk("t1_b_ready", b_ready, 1'b0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("t1_s_x_valid", s_x_valid, 1'b1);
        chk("t1_s_x", s_x, VEC_A);
        chk("t1_s_x_label", s_x_label, 8'hA5);
        chk("t1_inflight1", inflight, 3'd1);
        tick();
        chk("t1_s_x_valid_once", s_x_valid, 1'b0);
        chk("t1_s_x_hold", s_x, VEC_A);
        tick();
        chk("t1_m_valid_early", m_valid, 1'b0);
        tick();
        chk("t1_m_valid", m_valid, 1'b1);
        chk("t1_m_id", m_id, 1'b0);
        chk("t1_m_y", m_y, SORT_AB);
        chk("t1_m_y_label", m_y_label, 8'hA5);
        chk("t1_inflight0", inflight, 3'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t1_m_valid_after", m_valid, 1'b0);

        // Round-robin alternation with both requesters busy
        do_reset();
        m_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 60 && mid.size() < 6; c++) begin
            #1;
            if (a_ready) gq.push_back(1'b0);
            if (b_ready) gq.push_back(1'b1);
            if (m_valid) begin
                mid.push_back(m_id);
                mlab.push_back(m_y_label);
                mdat.push_back(m_y);
            end
            tick();
            if (gq.size() >= 6) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t2_grant_count", gq.size(), 6);
        chk("t2_result_count", mid.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_grant", (i < gq.size()) ? {1'b0, gq[i]} : 2'd2, i % 2);
            chk("t2_m_id", (i < mid.size()) ? {1'b0, mid[i]} : 2'd2, i % 2);
            chk("t2_m_y", (i < mdat.size()) ? mdat[i] : 64'h0, SORT_AB);
            chk("t2_m_label", (i < mlab.size()) ? mlab[i] : 8'h00, (i % 2) ? 8'h80 : 8'hA5);
        end
        m_ready = 1'b0;

        // Credit exhaustion and a single freed credit
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (a_ready || b_ready) n++;
            tick();
        end
        #1;
        chk("t3_accepts", n, 4);
        chk("t3_a_ready_zero", a_ready, 1'b0);
        chk("t3_b_ready_zero", b_ready, 1'b0);
        chk("t3_inflight", inflight, 3'd0);
        chk("t3_head_id", m_id, 1'b0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1;
        chk("t3_next_is_a", a_ready, 1'b1);
        chk("t3_head_id_next", m_id, 1'b1);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (a_ready || b_ready) n++;
            tick();
            #1;
        end
        chk("t3_extra_accepts", n, 1);
        a_valid = 1'b0; b_valid = 1'b0;

        // Issue and delivery together with one credit left
        do_reset();
        a_valid = 1'b1; a_x = VEC_A; a_x_label = 8'hA5;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            #1;
            if (a_ready) n++;
            tick();
        end
        a_valid = 1'b0;
        repeat (6) tick();
        chk("t4_inflight0", inflight, 3'd0);
        chk("t4_m_valid", m_valid, 1'b1);
        a_valid = 1'b1; m_ready = 1'b1;
        #1;
        chk("t4_ready_credit1", a_ready, 1'b1);
        tick();
        m_ready = 1'b0;
        #1;
        chk("t4_credit_kept", a_ready, 1'b1);
        chk("t4_inflight1", inflight, 3'd1);
        tick();
        #1;
        chk("t4_credit_zero", a_ready, 1'b0);
        a_valid = 1'b0; m_ready = 1'b1;
        repeat (10) tick();
        m_ready = 1'b0;
        chk("t4_drained", m_valid, 1'b0);

        // Spurious sorter return sets the sticky overflow
        do_reset();
        man_y = 64'h1111111111111111; man_sy = 1'b1;
        tick();
        man_sy = 1'b0;
        #1;
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_inflight", inflight, 3'd0);
        repeat (5) tick();
        chk("t5_overflow_sticky", overflow, 1'b1);
        do_reset();
        chk("t5_overflow_cleared", overflow, 1'b0);

        // Reset while busy, then a clean request
        a_valid = 1'b1; b_valid = 1'b1; a_x = VEC_A; b_x = VEC_B;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            #1;
            if (a_ready || b_ready) n++;
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("t6_m_valid_pre", m_valid, 1'b1);
        chk("t6_inflight_pre", inflight, 3'd2);
        a_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_m_valid", m_valid, 1'b0);
        chk("t6_rst_s_x_valid", s_x_valid, 1'b0);
        chk("t6_rst_inflight", inflight, 3'd0);
        chk("t6_rst_a_ready", a_ready, 1'b0);
        a_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        a_valid = 1'b1; a_x = VEC_C; a_x_label = 8'h0F;
        #1;
        chk("t6_post_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        for (int c = 0; c < 10 && !m_valid; c++) tick();
        chk("t6_post_m_valid", m_valid, 1'b1);
        chk("t6_post_m_id", m_id, 1'b0);
        chk("t6_post_m_y", m_y, SORT_C);
        chk("t6_post_m_label", m_y_label, 8'hF0);
        chk("t6_post_overflow", overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sort_8_scheduler.md
SORT_8_SCHEDULER -- requirements
Module: sort_8_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one data element.
REQ-002 SHALL have parameter LABEL_WIDTH, default 1, width of one label element.
REQ-003 SHALL have parameter DEPTH, default 4, result-buffer entries (power of 2, 2..16).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports a_valid in 1, a_ready out 1, a_x in 8*DATA_WIDTH, a_x_label in 8*LABEL_WIDTH: requester A vector request.
REQ-007 SHALL have ports b_valid in 1, b_ready out 1, b_x in 8*DATA_WIDTH, b_x_label in 8*LABEL_WIDTH: requester B vector request.
REQ-008 SHALL have ports s_x_valid out 1, s_x out 8*DATA_WIDTH, s_x_label out 8*LABEL_WIDTH: issue to the shared 8-input sorter.
REQ-009 SHALL have ports s_y_valid in 1, s_y in 8*DATA_WIDTH, s_y_label in 8*LABEL_WIDTH: sorted result from the sorter, in issue order, no backpressure.
REQ-010 SHALL have ports m_valid out 1, m_ready in 1, m_y out 8*DATA_WIDTH, m_y_label out 8*LABEL_WIDTH, m_id out 1 (0=A, 1=B): result delivery.
REQ-011 SHALL have ports inflight out clog2(DEPTH)+1 (issued, not yet returned by sorter) and overflow out 1 (sticky error).

Function
REQ-012 A request SHALL be accepted on a cycle where x_valid and x_ready are both 1.
REQ-013 a_ready/b_ready SHALL be combinational: at most one high per cycle, and only when credit > 0.
REQ-014 Credit SHALL equal DEPTH minus (inflight + buffered results); reset value DEPTH.
REQ-015 Arbitration SHALL be round-robin: only one valid -> that one granted; both valid -> the requester not granted last; pointer updates only on an accepted request.
REQ-016 On acceptance at edge N, s_x/s_x_label SHALL be registered from the granted requester and s_x_valid SHALL be 1 for exactly the cycle after edge N.
REQ-017 s_x/s_x_label SHALL hold their last value while s_x_valid is 0.
REQ-018 On each issue, the granted id SHALL be pushed into an in-order id FIFO of DEPTH entries; inflight increments.
REQ-019 On s_y_valid, s_y/s_y_label and the popped id SHALL be written into the result buffer; inflight decrements.
REQ-020 Issue and return in the same cycle SHALL leave inflight unchanged.
REQ-021 m_valid SHALL be 1 iff the result buffer is non-empty; m_y, m_y_label, m_id SHALL show the head entry (show-ahead) and stay stable until m_valid and m_ready both 1.
REQ-022 A result written at edge N SHALL be visible on m_* from the cycle after edge N, even if the buffer was empty (no bypass).
REQ-023 A delivery handshake SHALL free one credit; issue and delivery in the same cycle SHALL leave credit unchanged.
REQ-024 With credit 0, a_ready and b_ready SHALL be 0; a delivery at edge N SHALL allow acceptance in the cycle after N.
REQ-025 s_y_valid with inflight = 0 or buffer full SHALL set overflow and be dropped; overflow clears only on reset.
REQ-026 Results SHALL leave in issue order regardless of requester.

Reset
REQ-027 Asserting rst SHALL immediately force s_x_valid=0, m_valid=0, a_ready=0, b_ready=0, inflight=0, overflow=0, credit=DEPTH, both FIFOs empty, RR pointer favouring A.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered results; s_y_valid arriving after reset release with inflight=0 SHALL set overflow.
REQ-029 s_x and m_y data registers SHALL reset to 0.

Verification
REQ-030 Single A request x=0x0706050403020100, model sorter latency 3 -> s_x_valid one cycle after acceptance; m_valid with m_id=0 one cycle after s_y_valid; inflight returns to 0.
REQ-031 a_valid and b_valid held high 6 cycles, m_ready=1 -> grants alternate A,B,A,B,A,B; m_id sequence 0,1,0,1,0,1.
REQ-032 DEPTH=4, m_ready=0, both valid -> exactly 4 acceptances, then ready low; one m_ready pulse -> exactly one further acceptance next cycle.
REQ-033 Issue and m handshake in the same cycle with credit 1 -> credit stays 1, no stall on next request.
REQ-034 s_y_valid pulsed with inflight=0 -> overflow=1, m_valid stays 0, overflow holds until rst.
REQ-035 rst asserted with 2 in flight and 1 buffered -> m_valid, s_x_valid, inflight drop to 0 within the reset cycle; post-reset A request completes normally with m_id=0.
